// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes engine: substitutes a WORD_BYTES-wide state word
// through LANES shared S-box lanes per cycle, forward or inverse per word.
module sub_bytes_engine #(
   parameter int WORD_BYTES = 16,
   parameter int LANES      = 4,
   parameter int INVERSE_EN = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*WORD_BYTES-1:0] in_data,
   input  logic                    in_inv,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [8*WORD_BYTES-1:0] out_data,
   output logic                    busy
);

   localparam int GROUPS = (LANES > 0) ? WORD_BYTES / LANES : 1;
   localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   if (LANES == 0) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be nonzero");
   end else if (WORD_BYTES % LANES != 0) begin : g_bad_ratio
      $error("sub_bytes_engine: WORD_BYTES must be a multiple of LANES");
   end

   // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] FWD_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [2047:0] invert_table(input logic [2047:0] t);
      logic [2047:0] r;
      r = '0;
      for (int i = 0; i < 256; i++) begin
         r[2047 - 8*int'(t[2047 - 8*i -: 8]) -: 8] = 8'(i);
      end
      return r;
   endfunction

   localparam logic [2047:0] INV_TABLE = invert_table(FWD_TABLE);

   function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
      if (INVERSE_EN != 0 && inv) return INV_TABLE[2047 - 8*int'(b) -: 8];
      return FWD_TABLE[2047 - 8*int'(b) -: 8];
   endfunction

   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [8*WORD_BYTES-1:0] data_q, data_d;
   logic                    inv_q, inv_d;

   always_comb begin
      int idx;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      inv_d   = inv_q;
      idx     = 0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               inv_d   = in_inv & (INVERSE_EN != 0);
               cnt_d   = '0;
               state_d = SUB;
            end
         end
         SUB: begin
            for (int l = 0; l < LANES; l++) begin
               idx = int'(cnt_q) * LANES + l;
               data_d[8*idx +: 8] = sub_byte(data_q[8*idx +: 8], inv_q);
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (int'(cnt_q) == GROUPS - 1) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         inv_q   <= inv_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = data_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine: fixed vectors, corner sequences and
// random words checked against a GF(2^8) arithmetic model of the S-box.
module tb_sub_bytes_engine;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_inv = 1'b0;
   logic         out_ready = 1'b1;
   logic         in_valid_v [4];
   logic         in_ready_v [4];
   logic         out_valid_v [4];
   logic         busy_v [4];
   logic [127:0] out_data_v [4];

   int errors = 0;
   int checks = 0;
   int lat_tab [4] = '{4, 16, 1, 4};
   logic [7:0] fwd_m [256];
   logic [7:0] inv_m [256];

   always #5 clk = ~clk;

   sub_bytes_engine #(.WORD_BYTES(16), .LANES(4), .INVERSE_EN(1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[0]),
      .out_ready(out_ready), .out_data(out_data_v[0]), .busy(busy_v[0]));
   sub_bytes_engine #(.WORD_BYTES(16), .LANES(1), .INVERSE_EN(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[1]),
      .out_ready(out_ready), .out_data(out_data_v[1]), .busy(busy_v[1]));
   sub_bytes_engine #(.WORD_BYTES(16), .LANES(16), .INVERSE_EN(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[2]),
      .out_ready(out_ready), .out_data(out_data_v[2]), .busy(busy_v[2]));
   sub_bytes_engine #(.WORD_BYTES(16), .LANES(4), .INVERSE_EN(0)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[3]),
      .out_ready(out_ready), .out_data(out_data_v[3]), .busy(busy_v[3]));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference S-box from first principles: multiplicative inverse in GF(2^8), then affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] model_sbox(input logic [7:0] x);
      logic [7:0] r = '0;
      for (int y = 1; y < 256; y++)
         if (x != 0 && gmul(x, 8'(y)) == 8'h01) r = 8'(y);
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] model_word(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
      return r;
   endfunction

   // Accept one word on instance u, wait (bounded) for the result, then let it transfer.
   task automatic run_word(input int u, input logic [127:0] d, input logic inv,
                           input logic [127:0] exp, input string name);
      int n = 0;
      @(negedge clk);
      check({name, " in_ready idle"}, 128'(in_ready_v[u]), 128'd1);
      in_data = d; in_inv = inv; in_valid_v[u] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[u] = 1'b0;
      while (!out_valid_v[u] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " latency"}, 128'(n), 128'(lat_tab[u]));
      check({name, " data"}, out_data_v[u], exp);
      check({name, " in_ready done"}, 128'(in_ready_v[u]), 128'd0);
      @(posedge clk); #1;
      check({name, " out_valid after xfer"}, 128'(out_valid_v[u]), 128'd0);
      check({name, " back to idle"}, 128'({in_ready_v[u], busy_v[u]}), 128'b10);
   endtask

   typedef struct {
      int           unit;
      logic [127:0] data;
      logic         inv;
      logic [127:0] exp;
      string        name;
   } vec_t;

   vec_t vecs [7];
   logic [127:0] held;

   initial begin
      for (int i = 0; i < 4; i++) in_valid_v[i] = 1'b0;
      for (int i = 0; i < 256; i++) fwd_m[i] = model_sbox(8'(i));
      for (int i = 0; i < 256; i++) inv_m[fwd_m[i]] = 8'(i);

      vecs[0] = '{0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                  128'h76abd7fe2b670130c56f6bf27b777c63, "fwd_seq"};
      vecs[1] = '{0, 128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1,
                  128'h0f0e0d0c0b0a09080706050403020100, "inv_roundtrip"};
      vecs[2] = '{0, {16{8'h16}}, 1'b1, {16{8'hff}}, "inv_16"};
      vecs[3] = '{3, {16{8'h16}}, 1'b1, {16{8'h47}}, "inv_disabled"};
      vecs[4] = '{0, 128'he99aa019, 1'b0, {{12{8'h63}}, 32'h1eb8e0d4}, "fips197"};
      vecs[5] = '{1, {16{8'hff}}, 1'b0, {16{8'h16}}, "lanes1"};
      vecs[6] = '{2, {16{8'hff}}, 1'b0, {16{8'h16}}, "lanes16"};

      #12;
      check("reset out_valid", 128'(out_valid_v[0]), 128'd0);
      check("reset out_data", out_data_v[0], 128'd0);
      check("reset busy/in_ready", 128'({busy_v[0], in_ready_v[0]}), 128'b01);
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[i]) run_word(vecs[i].unit, vecs[i].data, vecs[i].inv, vecs[i].exp, vecs[i].name);

      // Backpressure: hold the result in DONE while the input side is noisy.
      out_ready = 1'b0;
      @(negedge clk);
      in_data = {16{8'h00}}; in_inv = 1'b0; in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      held = out_data_v[0];
      check("bp first", held, {16{8'h63}});
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid_v[0] = c[0] ? 1'b0 : 1'b1;
         in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_inv = ~in_inv;
         @(posedge clk); #1;
         check("bp out_valid", 128'(out_valid_v[0]), 128'd1);
         check("bp out_data", out_data_v[0], held);
         check("bp in_ready", 128'(in_ready_v[0]), 128'd0);
      end
      @(negedge clk); in_valid_v[0] = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp transfer", 128'({out_valid_v[0], in_ready_v[0]}), 128'b01);
      @(posedge clk); #1;
      check("bp no extra word", 128'(busy_v[0]), 128'd0);

      // Reset in the middle of SUB.
      @(negedge clk);
      in_data = {16{8'h11}}; in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst mid out_valid", 128'(out_valid_v[0]), 128'd0);
      check("rst mid busy/in_ready", 128'({busy_v[0], in_ready_v[0]}), 128'b01);
      @(negedge clk); rst_n = 1'b1;
      run_word(0, {16{8'h53}}, 1'b0, {16{8'hed}}, "after_reset");

      // Random words on every instance against the arithmetic model.
      for (int i = 0; i < 24; i++) begin
         int u;
         logic [127:0] d;
         logic inv;
         u = int'($urandom_range(0, 3));
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         inv = 1'($urandom_range(0, 1));
         run_word(u, d, inv, model_word(d, inv && u != 3), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
